// File: rtl/router_fsm_nch.sv
// Control FSM for a 1xN packet router: steers header/payload/parity writes into the
// addressed FIFO, drops packets with bad addresses or stuck destinations.
module router_fsm_nch #(
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 8,
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] din,
  input  logic [NUM_CH-1:0] fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] sft_rst,
  input  logic              parity_done,
  input  logic              low_pkt_vld,
  output logic [ADDR_W-1:0] dest_addr,
  output logic              wr_enb_reg,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              drop_state,
  output logic              addr_err,
  output logic              timeout_err,
  output logic              busy,
  output logic [3:0]        state_dbg
);

  // Handshake: the source may advance din only in a cycle where busy=0; while busy=1
  // it must hold pkt_valid and din stable. wr_enb_reg=1 means din is written this cycle.

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    WAIT_TILL_EMPTY    = 4'd1,
    LOAD_FIRST_DATA    = 4'd2,
    LOAD_DATA          = 4'd3,
    FIFO_FULL_STATE    = 4'd4,
    LOAD_AFTER_FULL    = 4'd5,
    LOAD_PARITY        = 4'd6,
    CHECK_PARITY_ERROR = 4'd7,
    DROP_PKT           = 4'd8
  } state_t;

  localparam logic [16:0] TMO_LIMIT = 17'(WAIT_TIMEOUT);

  state_t            state;
  state_t            next_state;
  logic [15:0]       wait_cnt;
  logic [ADDR_W-1:0] hdr_addr;
  logic              hdr_bad;
  logic              hdr_empty;
  logic              cur_full;
  logic              cur_empty;
  logic              cur_sft;
  logic              timeout_hit;
  logic              load_dest;
  logic              addr_err_nxt;
  logic              timeout_nxt;

  assign hdr_addr = din[ADDR_W-1:0];
  assign hdr_bad  = ({1'b0, hdr_addr} >= (ADDR_W+1)'(NUM_CH));

  // Channel lookups; an out-of-range index reads as 0 on every status line.
  always_comb begin
    hdr_empty = 1'b0;
    cur_full  = 1'b0;
    cur_empty = 1'b0;
    cur_sft   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (hdr_addr == ADDR_W'(i)) hdr_empty = fifo_empty[i];
      if (dest_addr == ADDR_W'(i)) begin
        cur_full  = fifo_full[i];
        cur_empty = fifo_empty[i];
        cur_sft   = sft_rst[i];
      end
    end
  end

  // wait_cnt is 0 on the first WAIT_TILL_EMPTY cycle, so +1 gives cycles spent so far.
  assign timeout_hit = (WAIT_TIMEOUT != 0) && (({1'b0, wait_cnt} + 17'd1) >= TMO_LIMIT);

  always_comb begin
    next_state   = state;
    load_dest    = 1'b0;
    addr_err_nxt = 1'b0;
    timeout_nxt  = 1'b0;
    if (cur_sft && (state != DECODE_ADDRESS) && (state != DROP_PKT)) begin
      next_state = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (pkt_valid) begin
            load_dest = 1'b1;
            if (hdr_bad) begin
              next_state   = DROP_PKT;
              addr_err_nxt = 1'b1;
            end else if (hdr_empty) begin
              next_state = LOAD_FIRST_DATA;
            end else begin
              next_state = WAIT_TILL_EMPTY;
            end
          end
        end
        WAIT_TILL_EMPTY: begin
          if (cur_empty) begin
            next_state = LOAD_FIRST_DATA;
          end else if (timeout_hit) begin
            next_state  = DROP_PKT;
            timeout_nxt = 1'b1;
          end
        end
        LOAD_FIRST_DATA: next_state = LOAD_DATA;
        LOAD_DATA: begin
          if (cur_full)        next_state = FIFO_FULL_STATE;
          else if (!pkt_valid) next_state = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!cur_full) next_state = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)      next_state = DECODE_ADDRESS;
          else if (low_pkt_vld) next_state = LOAD_PARITY;
          else                  next_state = LOAD_DATA;
        end
        LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          if (cur_full) next_state = FIFO_FULL_STATE;
          else          next_state = DECODE_ADDRESS;
        end
        DROP_PKT: begin
          if (!pkt_valid) next_state = DECODE_ADDRESS;
        end
        default: next_state = DECODE_ADDRESS;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= DECODE_ADDRESS;
      dest_addr   <= '0;
      wait_cnt    <= '0;
      addr_err    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= next_state;
      addr_err    <= addr_err_nxt;
      timeout_err <= timeout_nxt;
      if (load_dest) dest_addr <= hdr_addr;
      if (state != WAIT_TILL_EMPTY)  wait_cnt <= '0;
      else if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
    end
  end

  always_comb begin
    busy       = 1'b0;
    wr_enb_reg = 1'b0;
    case (state)
      WAIT_TILL_EMPTY:    busy = 1'b1;
      LOAD_FIRST_DATA:    begin busy = 1'b1; wr_enb_reg = 1'b1; end
      LOAD_DATA:          wr_enb_reg = 1'b1;
      FIFO_FULL_STATE:    busy = 1'b1;
      LOAD_AFTER_FULL:    begin busy = 1'b1; wr_enb_reg = 1'b1; end
      LOAD_PARITY:        begin busy = 1'b1; wr_enb_reg = 1'b1; end
      CHECK_PARITY_ERROR: busy = 1'b1;
      default:            begin busy = 1'b0; wr_enb_reg = 1'b0; end
    endcase
  end

  assign detect_add  = (state == DECODE_ADDRESS);
  assign lfd_state   = (state == LOAD_FIRST_DATA);
  assign ld_state    = (state == LOAD_DATA);
  assign laf_state   = (state == LOAD_AFTER_FULL);
  assign full_state  = (state == FIFO_FULL_STATE);
  assign rst_int_reg = (state == CHECK_PARITY_ERROR);
  assign drop_state  = (state == DROP_PKT);
  assign state_dbg   = state;

endmodule

// File: tb/tb_router_fsm_nch.sv
// Bench for router_fsm_nch: two instances (no timeout / timeout=4) share stimulus and are
// compared every cycle against a packet-level reference model, plus directed count checks.
module tb_router_fsm_nch;
  localparam int NUM_CH = 3;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 8;
  localparam int W      = 13;

  localparam int PH_DEC  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_LFD  = 2;
  localparam int PH_LD   = 3;
  localparam int PH_FULL = 4;
  localparam int PH_LAF  = 5;
  localparam int PH_LP   = 6;
  localparam int PH_CPE  = 7;
  localparam int PH_DROP = 8;

  logic clk = 1'b0;
  logic rstn;
  logic pkt_valid;
  logic [DATA_W-1:0] din;
  logic [NUM_CH-1:0] fifo_full, fifo_empty, sft_rst;
  logic parity_done, low_pkt_vld;

  logic [ADDR_W-1:0] dest_addr [2];
  logic wr_enb_reg [2], detect_add [2], lfd_state [2], ld_state [2], laf_state [2];
  logic full_state [2], rst_int_reg [2], drop_state [2], addr_err [2], timeout_err [2];
  logic busy [2];
  logic [3:0] state_dbg [2];

  router_fsm_nch #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_TIMEOUT(0)) dut0 (
    .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .din(din), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .sft_rst(sft_rst), .parity_done(parity_done),
    .low_pkt_vld(low_pkt_vld), .dest_addr(dest_addr[0]), .wr_enb_reg(wr_enb_reg[0]),
    .detect_add(detect_add[0]), .lfd_state(lfd_state[0]), .ld_state(ld_state[0]),
    .laf_state(laf_state[0]), .full_state(full_state[0]), .rst_int_reg(rst_int_reg[0]),
    .drop_state(drop_state[0]), .addr_err(addr_err[0]), .timeout_err(timeout_err[0]),
    .busy(busy[0]), .state_dbg(state_dbg[0]));

  router_fsm_nch #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_TIMEOUT(4)) dut4 (
    .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .din(din), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .sft_rst(sft_rst), .parity_done(parity_done),
    .low_pkt_vld(low_pkt_vld), .dest_addr(dest_addr[1]), .wr_enb_reg(wr_enb_reg[1]),
    .detect_add(detect_add[1]), .lfd_state(lfd_state[1]), .ld_state(ld_state[1]),
    .laf_state(laf_state[1]), .full_state(full_state[1]), .rst_int_reg(rst_int_reg[1]),
    .drop_state(drop_state[1]), .addr_err(addr_err[1]), .timeout_err(timeout_err[1]),
    .busy(busy[1]), .state_dbg(state_dbg[1]));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_ph [2];
  int          m_spent [2];
  logic [1:0]  m_dest [2];
  logic        m_aerr [2];
  logic        m_terr [2];
  int          tmo [2] = '{0, 4};
  logic [8:0]  busy_tab = 9'b011110110;
  logic [8:0]  wr_tab   = 9'b001101100;

  logic [W-1:0] exp_q [$];
  int checks   = 0;
  int failures = 0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = PH_DEC; m_spent[k] = 0; m_dest[k] = '0; m_aerr[k] = 1'b0; m_terr[k] = 1'b0;
    end
  endtask

  // Applies one clock edge of packet-level rules to each model instance.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int p  = m_ph[k];
      int np = m_ph[k];
      logic [1:0] a = din[1:0];
      logic sr = (m_dest[k] < 2'(NUM_CH)) ? sft_rst[m_dest[k]] : 1'b0;
      m_aerr[k] = 1'b0;
      m_terr[k] = 1'b0;
      if (sr && p != PH_DEC && p != PH_DROP) np = PH_DEC;
      else if (p == PH_DEC) begin
        if (pkt_valid) begin
          m_dest[k] = a;
          m_spent[k] = 0;
          if (a >= 2'(NUM_CH)) begin np = PH_DROP; m_aerr[k] = 1'b1; end
          else if (fifo_empty[a]) np = PH_LFD;
          else np = PH_WAIT;
        end
      end else if (p == PH_WAIT) begin
        m_spent[k]++;
        if (fifo_empty[m_dest[k]]) np = PH_LFD;
        else if (tmo[k] != 0 && m_spent[k] >= tmo[k]) begin np = PH_DROP; m_terr[k] = 1'b1; end
      end else if (p == PH_LFD) np = PH_LD;
      else if (p == PH_LD) begin
        if (fifo_full[m_dest[k]]) np = PH_FULL;
        else if (!pkt_valid) np = PH_LP;
      end else if (p == PH_FULL) begin
        if (!fifo_full[m_dest[k]]) np = PH_LAF;
      end else if (p == PH_LAF) begin
        np = parity_done ? PH_DEC : (low_pkt_vld ? PH_LP : PH_LD);
      end else if (p == PH_LP) np = PH_CPE;
      else if (p == PH_CPE) np = fifo_full[m_dest[k]] ? PH_FULL : PH_DEC;
      else if (p == PH_DROP) begin
        if (!pkt_valid) np = PH_DEC;
      end
      m_ph[k] = np;
    end
  endtask

  function automatic logic [W-1:0] exp_vec(int k);
    int p = m_ph[k];
    return {p == PH_DEC, p == PH_LFD, p == PH_LD, p == PH_LAF, p == PH_FULL, p == PH_CPE,
            p == PH_DROP, busy_tab[p], wr_tab[p], m_aerr[k], m_terr[k], m_dest[k]};
  endfunction

  function automatic logic [W-1:0] obs_vec(int k);
    return {detect_add[k], lfd_state[k], ld_state[k], laf_state[k], full_state[k],
            rst_int_reg[k], drop_state[k], busy[k], wr_enb_reg[k], addr_err[k],
            timeout_err[k], dest_addr[k]};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_vec(string tag, int k, logic [W-1:0] exp);
    logic [W-1:0] obs = obs_vec(k);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic check_int(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(bit pv, logic [7:0] d, logic [2:0] full_i, logic [2:0] empty_i,
                       logic [2:0] sr_i, bit pd, bit lpv);
    pkt_valid = pv; din = d; fifo_full = full_i; fifo_empty = empty_i;
    sft_rst = sr_i; parity_done = pd; low_pkt_vld = lpv;
  endtask

  task automatic step(string tag);
    model_step();
    for (int k = 0; k < 2; k++) exp_q.push_back(exp_vec(k));
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) check_vec(tag, k, exp_q.pop_front());
  endtask

  task automatic async_reset(string tag);
    #2 rstn = 1'b0;
    #1 model_reset();
    for (int k = 0; k < 2; k++) check_vec(tag, k, exp_vec(k));
    #1 rstn = 1'b1;
  endtask

  task automatic idle(int n);
    drive(0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0);
    for (int i = 0; i < n; i++) step("idle");
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int cnt;
    int cnt2;
    rstn = 1'b0;
    drive(0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0);
    model_reset();
    #3;
    for (int k = 0; k < 2; k++) check_vec("reset", k, exp_vec(k));
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) check_vec("reset_hold", k, exp_vec(k));
    rstn = 1'b1;

    // 1: clean packet to ch1
    cnt = 0;
    drive(1, 8'h01, 3'b000, 3'b111, 3'b000, 0, 0); step("t1_hdr"); cnt += int'(wr_enb_reg[0]);
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'($urandom), 3'b000, 3'b111, 3'b000, 0, 0); step("t1_pay"); cnt += int'(wr_enb_reg[0]);
    end
    drive(0, 8'h5a, 3'b000, 3'b111, 3'b000, 0, 0);
    for (int i = 0; i < 3; i++) begin step("t1_tail"); cnt += int'(wr_enb_reg[0]); end
    check_int("t1_wr_cycles", cnt, 6);
    check_int("t1_dest", int'(dest_addr[0]), 1);
    check_int("t1_back_in_decode", int'(detect_add[0]), 1);

    // 2: ch2 not empty for 5 cycles; dut0 waits, dut4 times out
    cnt = 0;
    drive(1, 8'h02, 3'b000, 3'b011, 3'b000, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step("t2_wait");
      cnt += int'(busy[0] && !wr_enb_reg[0] && !full_state[0] && !rst_int_reg[0]);
    end
    check_int("t2_wait_busy_cycles", cnt, 5);
    drive(1, 8'h33, 3'b000, 3'b111, 3'b000, 0, 0); step("t2_release");
    check_int("t2_lfd", int'(lfd_state[0]), 1);
    drive(0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0);
    for (int i = 0; i < 4; i++) step("t2_tail");

    // 3: bad address 3 is dropped
    cnt = 0; cnt2 = 0;
    drive(1, 8'h03, 3'b000, 3'b111, 3'b000, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step("t3_drop"); cnt += int'(addr_err[0]); cnt2 += int'(wr_enb_reg[0]);
    end
    drive(0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step("t3_end"); cnt += int'(addr_err[0]); cnt2 += int'(wr_enb_reg[0]);
    end
    check_int("t3_addr_err_pulses", cnt, 1);
    check_int("t3_no_writes", cnt2, 0);

    // 4: full stall on ch0, exit via low_pkt_vld then via parity_done
    for (int r = 0; r < 2; r++) begin
      cnt = 0;
      drive(1, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0); step("t4_hdr"); step("t4_lfd");
      drive(1, 8'h11, 3'b001, 3'b111, 3'b000, 0, 0);
      for (int i = 0; i < 3; i++) begin step("t4_full"); cnt += int'(full_state[0]); end
      check_int("t4_full_cycles", cnt, 3);
      drive(1, 8'h22, 3'b000, 3'b111, 3'b000, 0, 0); step("t4_laf");
      check_int("t4_laf", int'(laf_state[0]), 1);
      drive(0, 8'h22, 3'b000, 3'b111, 3'b000, r == 1, r == 0); step("t4_exit");
      if (r == 0) check_int("t4_to_parity", int'(wr_enb_reg[0] && busy[0] && !laf_state[0] && !lfd_state[0]), 1);
      else        check_int("t4_to_decode", int'(detect_add[0]), 1);
      idle(3);
    end

    // 5: ch0 never empty; dut4 times out after 4 wait cycles
    cnt = 0;
    drive(1, 8'h00, 3'b000, 3'b000, 3'b000, 0, 0);
    for (int i = 0; i < 7; i++) begin step("t5_wait"); cnt += int'(timeout_err[1]); end
    check_int("t5_timeout_pulses", cnt, 1);
    check_int("t5_dut4_drop", int'(drop_state[1]), 1);
    idle(5);

    // 6: soft reset on ch1 honoured, on ch0 ignored
    drive(1, 8'h01, 3'b000, 3'b111, 3'b000, 0, 0); step("t6_hdr"); step("t6_lfd");
    drive(1, 8'h44, 3'b000, 3'b111, 3'b001, 0, 0); step("t6_sr_other");
    check_int("t6_still_ld", int'(ld_state[0]), 1);
    drive(1, 8'h44, 3'b000, 3'b111, 3'b010, 0, 0); step("t6_sr_own");
    check_int("t6_decode", int'(detect_add[0]), 1);
    idle(2);

    // async reset mid-packet
    drive(1, 8'h02, 3'b000, 3'b111, 3'b000, 0, 0); step("ar_hdr"); step("ar_lfd");
    async_reset("async_reset");
    idle(2);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 9) < 7, 8'($urandom),
            {$urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0},
            {$urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0},
            ($urandom_range(0, 29) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      step("random");
      if ($urandom_range(0, 299) == 0) async_reset("random_reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
